// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU operations, MDU operations,
// destination-register select and the MDU sequencer states.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_ctl_e;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MFHI  = 3'd5,
    MDU_MFLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    REGDST_RT   = 2'd0,
    REGDST_RD   = 2'd1,
    REGDST_LINK = 2'd2
  } regdst_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/exec_stage_mdu_mdu_iterative.sv
// Iterative multiply/divide unit owning HI/LO: one bit per cycle on magnitudes,
// sign fix-up in a final cycle. The divider is only built with EXEC_DIV_EN.
module mdu_iterative
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  mdu_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   work_hi_q, work_lo_q, opnd_q, hi_q, lo_q;
  logic                neg_q;
  logic                op_signed, a_neg, b_neg, go_mul, go_div;
  logic [DATA_W-1:0]   a_mag, b_mag, step_hi, step_lo, fix_hi, fix_lo;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] prod_fix;
`ifdef EXEC_DIV_EN
  logic                is_div_q, neg_rem_q;
  logic [DATA_W:0]     rem_sh;
`endif

  assign go_mul = start && (op == MDU_MULT || op == MDU_MULTU);
`ifdef EXEC_DIV_EN
  assign go_div = start && (op == MDU_DIV || op == MDU_DIVU);
`else
  assign go_div = 1'b0;
`endif

  assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign a_neg     = op_signed & a[DATA_W-1];
  assign b_neg     = op_signed & b[DATA_W-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign busy      = (state_q != MDU_IDLE);
  assign hi        = hi_q;
  assign lo        = lo_q;

  // work_hi holds the partial product / remainder, work_lo the multiplier / quotient.
  always_comb begin
    mul_sum  = {1'b0, work_hi_q} + {1'b0, {DATA_W{work_lo_q[0]}} & opnd_q};
    step_hi  = mul_sum[DATA_W:1];
    step_lo  = {mul_sum[0], work_lo_q[DATA_W-1:1]};
    prod_fix = neg_q ? -{work_hi_q, work_lo_q} : {work_hi_q, work_lo_q};
    fix_hi   = prod_fix[2*DATA_W-1:DATA_W];
    fix_lo   = prod_fix[DATA_W-1:0];
`ifdef EXEC_DIV_EN
    rem_sh = {work_hi_q, work_lo_q[DATA_W-1]};
    if (is_div_q) begin
      if (rem_sh >= {1'b0, opnd_q}) begin
        step_hi = DATA_W'(rem_sh - {1'b0, opnd_q});
        step_lo = {work_lo_q[DATA_W-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[DATA_W-1:0];
        step_lo = {work_lo_q[DATA_W-2:0], 1'b0};
      end
      fix_hi = neg_rem_q ? -work_hi_q : work_hi_q;
      fix_lo = neg_q ? -work_lo_q : work_lo_q;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef EXEC_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (go_mul || go_div) begin
            state_q   <= MDU_RUN;
            cnt_q     <= CNT_W'(DATA_W - 1);
            work_hi_q <= '0;
            work_lo_q <= go_div ? a_mag : b_mag;
            opnd_q    <= go_div ? b_mag : a_mag;
            // A zero divisor yields an all-ones quotient that must not be negated.
            neg_q     <= (a_neg ^ b_neg) & ~(go_div & (b == '0));
`ifdef EXEC_DIV_EN
            is_div_q  <= go_div;
            neg_rem_q <= a_neg;
`endif
          end
        end
        MDU_RUN: begin
          work_hi_q <= step_hi;
          work_lo_q <= step_lo;
          if (cnt_q == '0) state_q <= MDU_FIX;
          else cnt_q <= cnt_q - CNT_W'(1);
        end
        MDU_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          state_q <= MDU_IDLE;
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/exec_stage_mdu.sv
// Pipelined execute stage: ALU, operand/destination muxes, branch/JR targets and
// the EX/MEM register, plus an iterative MDU. EXEC_DIV_EN enables DIV/DIVU.
module exec_stage_mdu
  import exec_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  in_valid,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     rs_data,
  input  logic [DATA_W-1:0]     rt_data,
  input  logic [DATA_W-1:0]     imm,
  input  logic [4:0]            shamt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [DATA_W-1:0]     pc,
  input  logic                  alusrc,
  input  logic [1:0]            regdst,
  input  logic [3:0]            alu_ctl,
  input  logic [2:0]            mdu_op,
  input  logic                  regwrite,
  input  logic                  memwrite,
  input  logic                  memread,
  input  logic [1:0]            memtoreg,
  output logic                  stall_out,
  output logic                  ex_valid,
  output logic                  ex_zero,
  output logic [DATA_W-1:0]     ex_result,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_branch_target,
  output logic [DATA_W-1:0]     ex_jr_target,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [REG_ADDR_W-1:0] ex_wr_reg,
  output logic                  ex_regwrite,
  output logic                  ex_memwrite,
  output logic                  ex_memread,
  output logic [1:0]            ex_memtoreg
);
  logic                  mdu_busy, mdu_arith, mdu_hazard, acc, load;
  logic [DATA_W-1:0]     mdu_hi, mdu_lo, alu_b, alu_res, result_d;
  logic [REG_ADDR_W-1:0] wr_reg_d;

  assign mdu_arith  = (mdu_op >= MDU_MULT) && (mdu_op <= MDU_DIVU);
  assign mdu_hazard = mdu_busy && (mdu_op >= MDU_MULT) && (mdu_op <= MDU_MFLO);
  assign stall_out  = hold | mdu_hazard;
  assign acc        = in_valid & ~stall_out;
  assign load       = acc & ~flush;

  mdu_iterative #(.DATA_W(DATA_W)) u_mdu (
    .Clk   (Clk),
    .Reset (Reset),
    .start (load),
    .op    (mdu_op),
    .a     (rs_data),
    .b     (rt_data),
    .busy  (mdu_busy),
    .hi    (mdu_hi),
    .lo    (mdu_lo)
  );

  always_comb begin
    alu_b   = alusrc ? imm : rt_data;
    alu_res = '0;
    case (alu_ctl)
      ALU_AND:  alu_res = rs_data & alu_b;
      ALU_OR:   alu_res = rs_data | alu_b;
      ALU_ADD:  alu_res = rs_data + alu_b;
      ALU_SUB:  alu_res = rs_data - alu_b;
      ALU_XOR:  alu_res = rs_data ^ alu_b;
      ALU_NOR:  alu_res = ~(rs_data | alu_b);
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(rs_data) < $signed(alu_b)};
      ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, rs_data < alu_b};
      ALU_SLL:  alu_res = alu_b << shamt;
      ALU_SRL:  alu_res = alu_b >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(alu_b) >>> shamt);
      ALU_LUI:  alu_res = alu_b << 16;
      default:  alu_res = '0;
    endcase

    case (mdu_op)
      MDU_MFHI: result_d = mdu_hi;
      MDU_MFLO: result_d = mdu_lo;
      default:  result_d = alu_res;
    endcase

    case (regdst)
      REGDST_RD:   wr_reg_d = rd;
      REGDST_LINK: wr_reg_d = REG_ADDR_W'(LINK_REG);
      default:     wr_reg_d = rt;
    endcase
  end

  // Data fields load even on a bubble; only valid and the controls matter then.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_valid         <= 1'b0;
      ex_zero          <= 1'b0;
      ex_result        <= '0;
      ex_rt_data       <= '0;
      ex_branch_target <= '0;
      ex_jr_target     <= '0;
      ex_pc            <= '0;
      ex_wr_reg        <= '0;
      ex_regwrite      <= 1'b0;
      ex_memwrite      <= 1'b0;
      ex_memread       <= 1'b0;
      ex_memtoreg      <= 2'b00;
    end else if (!hold) begin
      ex_valid         <= load;
      ex_regwrite      <= load & regwrite & ~mdu_arith;
      ex_memwrite      <= load & memwrite;
      ex_memread       <= load & memread;
      ex_memtoreg      <= load ? memtoreg : 2'b00;
      ex_zero          <= (alu_res == '0);
      ex_result        <= result_d;
      ex_rt_data       <= rt_data;
      ex_branch_target <= pc + {imm[DATA_W-3:0], 2'b00};
      ex_jr_target     <= rs_data;
      ex_pc            <= pc;
      ex_wr_reg        <= wr_reg_d;
    end
  end

endmodule

// File: tb/tb_exec_stage_mdu.sv
// Randomised self-checking bench for exec_stage_mdu against an arithmetic reference model.
module tb_exec_stage_mdu;
  localparam int W = 32;
`ifdef EXEC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset, in_valid, hold, flush, alusrc, regwrite, memwrite, memread;
  logic [W-1:0] rs_data, rt_data, imm, pc;
  logic [4:0]   shamt, rd, rt;
  logic [1:0]   regdst, memtoreg;
  logic [3:0]   alu_ctl;
  logic [2:0]   mdu_op;
  logic         stall_out, ex_valid, ex_zero, ex_regwrite, ex_memwrite, ex_memread;
  logic [W-1:0] ex_result, ex_rt_data, ex_branch_target, ex_jr_target, ex_pc;
  logic [4:0]   ex_wr_reg;
  logic [1:0]   ex_memtoreg;

  always #5 Clk = ~Clk;

  exec_stage_mdu #(.DATA_W(W), .REG_ADDR_W(5), .LINK_REG(31)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .hold(hold), .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .shamt(shamt), .rd(rd), .rt(rt),
    .pc(pc), .alusrc(alusrc), .regdst(regdst), .alu_ctl(alu_ctl), .mdu_op(mdu_op),
    .regwrite(regwrite), .memwrite(memwrite), .memread(memread), .memtoreg(memtoreg),
    .stall_out(stall_out), .ex_valid(ex_valid), .ex_zero(ex_zero), .ex_result(ex_result),
    .ex_rt_data(ex_rt_data), .ex_branch_target(ex_branch_target),
    .ex_jr_target(ex_jr_target), .ex_pc(ex_pc), .ex_wr_reg(ex_wr_reg),
    .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite), .ex_memread(ex_memread),
    .ex_memtoreg(ex_memtoreg)
  );

  int total = 0;
  int bad = 0;
  int txn = 0;
  bit last_stall;

  // Reference state: expected EX/MEM contents, HI/LO and remaining busy cycles.
  bit           m_valid, m_rw, m_mw, m_mr, m_zero, m_known;
  logic [1:0]   m_mtr;
  logic [4:0]   m_wr;
  logic [W-1:0] m_res, m_bt, m_jr, m_pc, m_rt, m_hi, m_lo, p_hi, p_lo;
  int           m_busy;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [4:0] sh);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (sa < sb) ? 1 : 0;
      4'd7:  return (a < b) ? 1 : 0;
      4'd8:  return b * (32'd1 << sh);
      4'd9:  return b / (32'd1 << sh);
      4'd10: return W'(sb >>> sh);
      4'd11: return b * 32'h10000;
      default: return '0;
    endcase
  endfunction

  task automatic ref_mdu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi_v, output logic [W-1:0] lo_v);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi_v = '0;
    lo_v = '0;
    case (op)
      3'd1: begin p = 64'(sa * sb); hi_v = p[63:32]; lo_v = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; hi_v = p[63:32]; lo_v = p[31:0]; end
      3'd3: begin
        if (b == 0) begin hi_v = a; lo_v = '1; end
        else begin q = sa / sb; r = sa % sb; lo_v = W'(q); hi_v = W'(r); end
      end
      3'd4: begin
        if (b == 0) begin hi_v = a; lo_v = '1; end
        else begin lo_v = a / b; hi_v = a % b; end
      end
      default: ;
    endcase
  endtask

  // One clock: predict, apply the edge, compare.
  task automatic step();
    bit arith, stall_e, load_e;
    logic [W-1:0] bop;
    #1;
    arith   = (mdu_op >= 1 && mdu_op <= 4);
    stall_e = hold || (m_busy > 0 && mdu_op >= 1 && mdu_op <= 6);
    last_stall = stall_out;
    check_val("stall", stall_out, stall_e);
    load_e = in_valid && !stall_e && !flush;
    if (Reset) begin
      m_valid = 0; m_rw = 0; m_mw = 0; m_mr = 0; m_mtr = 0; m_zero = 0; m_known = 1;
      m_res = 0; m_bt = 0; m_jr = 0; m_pc = 0; m_rt = 0; m_wr = 0;
      m_busy = 0; m_hi = 0; m_lo = 0;
    end else begin
      if (!hold) begin
        m_valid = load_e;
        m_rw    = load_e && regwrite && !arith;
        m_mw    = load_e && memwrite;
        m_mr    = load_e && memread;
        m_mtr   = load_e ? memtoreg : 2'b00;
        m_known = load_e;
        if (load_e) begin
          bop    = alusrc ? imm : rt_data;
          m_zero = (ref_alu(alu_ctl, rs_data, bop, shamt) == 0);
          m_res  = (mdu_op == 5) ? m_hi : (mdu_op == 6) ? m_lo : ref_alu(alu_ctl, rs_data, bop, shamt);
          m_wr   = (regdst == 1) ? rd : (regdst == 2) ? 5'd31 : rt;
          m_bt   = pc + imm * 4;
          m_jr   = rs_data;
          m_pc   = pc;
          m_rt   = rt_data;
        end
      end
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (load_e && (mdu_op == 1 || mdu_op == 2 || (DIV_EN && (mdu_op == 3 || mdu_op == 4)))) begin
        m_busy = W + 1;
        ref_mdu(mdu_op, rs_data, rt_data, p_hi, p_lo);
      end
    end
    @(posedge Clk);
    #1;
    txn++;
    $display("txn %0d rst=%0b v=%0b hold=%0b flush=%0b ctl=%0d mdu=%0d stall=%0b -> ex_v=%0b res=%h",
             txn, Reset, in_valid, hold, flush, alu_ctl, mdu_op, last_stall, ex_valid, ex_result);
    check_val("valid", ex_valid, m_valid);
    check_val("ctrl", {ex_regwrite, ex_memwrite, ex_memread, ex_memtoreg}, {m_rw, m_mw, m_mr, m_mtr});
    if (m_known) begin
      check_val("result", ex_result, m_res);
      check_val("zero", ex_zero, m_zero);
      check_val("wr_reg", ex_wr_reg, m_wr);
      check_val("br_tgt", ex_branch_target, m_bt);
      check_val("jr_tgt", ex_jr_target, m_jr);
      check_val("pc", ex_pc, m_pc);
      check_val("rt_data", ex_rt_data, m_rt);
    end
  endtask

  task automatic set_instr(input logic [3:0] ctl, input logic [2:0] mop,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1; hold = 0; flush = 0; Reset = 0;
    rs_data = a; rt_data = b; imm = 0; shamt = 0; pc = 32'h100;
    rd = 5'd9; rt = 5'd4; alusrc = 0; regdst = 2'd1;
    alu_ctl = ctl; mdu_op = mop; regwrite = 1; memwrite = 0; memread = 0; memtoreg = 0;
  endtask

  task automatic rand_instr(input bit allow_mdu);
    logic [31:0] r;
    int k;
    r = $urandom;
    in_valid = ($urandom_range(0, 9) != 0);
    rs_data  = $urandom;
    rt_data  = ($urandom_range(0, 7) == 0) ? rs_data : $urandom;
    imm      = {{16{r[15]}}, r[15:0]};
    shamt    = 5'($urandom);
    rd       = 5'($urandom);
    rt       = 5'($urandom);
    pc       = $urandom & 32'hFFFF_FFFC;
    alusrc   = 1'($urandom);
    regdst   = 2'($urandom_range(0, 2));
    alu_ctl  = 4'($urandom_range(0, 11));
    regwrite = 1'($urandom);
    memwrite = 1'($urandom);
    memread  = 1'($urandom);
    memtoreg = 2'($urandom);
    mdu_op   = 0;
    if (allow_mdu) begin
      k = $urandom_range(0, 19);
      if (k < 3) mdu_op = 3'($urandom_range(1, 4));
      else if (k < 6) mdu_op = 3'($urandom_range(5, 6));
      if (mdu_op >= 3 && mdu_op <= 4 && $urandom_range(0, 5) == 0) rt_data = 0;
    end
  endtask

  // Issue an MDU op, then MFLO (counting stall cycles) and MFHI.
  task automatic mdu_seq(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int n, output logic [W-1:0] lo_v, output logic [W-1:0] hi_v);
    bit done;
    set_instr(4'd2, op, a, b);
    step();
    set_instr(4'd2, 3'd6, 0, 0);
    n = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (last_stall) n++;
      else done = 1;
    end
    lo_v = ex_result;
    set_instr(4'd2, 3'd5, 0, 0);
    step();
    hi_v = ex_result;
  endtask

  initial begin
    int n;
    logic [W-1:0] lo_v, hi_v;

    set_instr(4'd0, 3'd0, 0, 0);
    in_valid = 0;
    Reset = 1;
    m_busy = 0;
    m_known = 0;
    step();
    step();
    check_val("rst_stall", stall_out, 0);
    check_val("rst_result", ex_result, 0);

    // ADD with negative immediate feeding the branch target
    set_instr(4'd2, 3'd0, 5, 7);
    imm = 32'hFFFF_FFFF;
    step();
    check_val("t1_res", ex_result, 12);
    check_val("t1_wr", ex_wr_reg, 9);
    check_val("t1_bt", ex_branch_target, 32'hFC);
    check_val("t1_valid", ex_valid, 1);

    mdu_seq(3'd1, 32'hFFFF_FFFD, 7, n, lo_v, hi_v);
    check_val("t2_stall_cycles", n, 33);
    check_val("t2_mflo", lo_v, 32'hFFFF_FFEB);
    check_val("t2_mfhi", hi_v, 32'hFFFF_FFFF);

    mdu_seq(3'd4, 100, 7, n, lo_v, hi_v);
    check_val("t3_divu_stall", n, DIV_EN ? 33 : 0);
    mdu_seq(3'd3, 32'hFFFF_FFF9, 2, n, lo_v, hi_v);
`ifdef EXEC_DIV_EN
    check_val("t3_div_lo", lo_v, 32'hFFFF_FFFD);
    check_val("t3_div_hi", hi_v, 32'hFFFF_FFFF);
`endif
    mdu_seq(3'd3, 32'h1234, 0, n, lo_v, hi_v);
    check_val("t4_dz_stall", n, DIV_EN ? 33 : 0);
`ifdef EXEC_DIV_EN
    check_val("t4_dz_lo", lo_v, 32'hFFFF_FFFF);
    check_val("t4_dz_hi", hi_v, 32'h1234);
`endif

    // hold freezes EX/MEM, then a flush squashes
    set_instr(4'd2, 3'd0, 20, 22);
    step();
    set_instr(4'd3, 3'd0, 50, 1);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t5_frozen", ex_result, 42);
    end
    hold = 0;
    flush = 1;
    step();
    check_val("t5_flush_v", ex_valid, 0);
    check_val("t5_flush_rw", ex_regwrite, 0);

    // reset in the middle of a multiply
    set_instr(4'd2, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    step();
    set_instr(4'd2, 3'd0, 1, 2);
    for (int i = 0; i < 9; i++) step();
    Reset = 1;
    step();
    set_instr(4'd2, 3'd5, 0, 0);
    step();
    check_val("t6_mfhi", ex_result, 0);

    // randomised mix with hold and flush
    for (int i = 0; i < 400; i++) begin
      rand_instr(1'b1);
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      Reset = 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
